mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that answers the core's data-memory bus: rw_addr_mem, w_data_mem, r_ctrl_mem, w_ctrl_mem and r_data_mem. It sits beside data_mem on the same bus and decodes its own 16-byte window. Byte writes from store instructions are buffered in a FIFO and serialised as 8N1 frames on tx. The core polls status through loads.

---
 rtl/mmio_uart_tx_if.sv | 13 +
 rtl/mmio_uart_tx.sv | 177 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - data-memory bus bundle shared by the core and the MMIO UART transmitter
interface mmio_uart_tx_if;
    logic [31:0] rw_addr_mem;
    logic [31:0] w_data_mem;
    logic        r_ctrl_mem;
    logic        w_ctrl_mem;
    logic [31:0] r_data_mem;

    modport master (output rw_addr_mem, output w_data_mem, output r_ctrl_mem,
                    output w_ctrl_mem, input r_data_mem);
    modport slave  (input rw_addr_mem, input w_data_mem, input r_ctrl_mem,
                    input w_ctrl_mem, output r_data_mem);
endinterface

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO; MMIO_UART_TX_IRQ_EN adds the irq port
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    mmio_uart_tx_if.slave bus,
    output logic          tx
`ifdef MMIO_UART_TX_IRQ_EN
    ,
    output logic          irq
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [4:0]      r_count;
    logic            r_overflow, r_tx_en, r_tx;
    logic [15:0]     r_divisor, r_bitlen, r_baud;
    logic [7:0]      r_shift;
    logic [2:0]      r_idx;
    logic [31:0]     w_rdata;
    logic [1:0]      w_sel;
    logic            w_hit, w_wr, w_rd, w_push_req, w_push, w_pop;
    logic            w_full, w_empty, w_busy, w_bit_end, w_tx_nxt, w_irq_en_rd;

    assign w_hit      = (bus.rw_addr_mem[31:4] == BASE_ADDR[31:4]);
    assign w_sel      = bus.rw_addr_mem[3:2];
    assign w_wr       = bus.w_ctrl_mem && w_hit;
    assign w_rd       = bus.r_ctrl_mem && w_hit;
    assign w_full     = (r_count == 5'(FIFO_DEPTH));
    assign w_empty    = (r_count == 5'd0);
    assign w_busy     = (r_state != S_IDLE);
    assign w_bit_end  = (r_baud == r_bitlen - 16'd1);
    assign w_push_req = w_wr && (w_sel == 2'd0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign tx         = r_tx;

    wire w_unused = ^{bus.rw_addr_mem[1:0], bus.w_data_mem[31:16]};

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (r_tx_en && !w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx_nxt = 1'b0;
                if (w_bit_end) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_bit_end && (r_idx == 3'd7)) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // tx is registered from the state, so the line lags the FSM by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx     <= 1'b1;
            r_shift  <= 8'd0;
            r_bitlen <= 16'd1;
            r_baud   <= 16'd0;
            r_idx    <= 3'd0;
        end else begin
            r_tx <= w_tx_nxt;
            if (w_pop) begin
                r_shift  <= r_mem[r_rptr];
                r_bitlen <= r_divisor;
                r_baud   <= 16'd0;
                r_idx    <= 3'd0;
            end else if (w_busy) begin
                if (w_bit_end) begin
                    r_baud <= 16'd0;
                    if (r_state == S_DATA) begin
                        r_shift <= r_shift >> 1;
                        r_idx   <= r_idx + 3'd1;
                    end
                end else begin
                    r_baud <= r_baud + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= bus.w_data_mem[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= 5'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push)
                r_overflow <= 1'b1;
            else if (w_wr && (w_sel == 2'd3) && bus.w_data_mem[1])
                r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_divisor <= 16'(CLK_DIV);
            r_tx_en   <= 1'b0;
        end else if (w_wr) begin
            if (w_sel == 2'd2)
                r_divisor <= (bus.w_data_mem[15:0] == 16'd0) ? 16'd1 : bus.w_data_mem[15:0];
            if (w_sel == 2'd3)
                r_tx_en <= bus.w_data_mem[0];
        end
    end

`ifdef MMIO_UART_TX_IRQ_EN
    logic r_irq_en, r_irq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && (w_sel == 2'd3)) r_irq_en <= bus.w_data_mem[2];
            r_irq <= r_irq_en && w_empty && !w_busy;
        end
    end

    assign irq         = r_irq;
    assign w_irq_en_rd = r_irq_en;
`else
    assign w_irq_en_rd = 1'b0;
`endif

    always_comb begin
        w_rdata = 32'd0;
        if (w_rd) begin
            case (w_sel)
                2'd1:    w_rdata[8:0]  = {r_count, r_overflow, w_empty, w_full, w_busy};
                2'd2:    w_rdata[15:0] = r_divisor;
                2'd3:    w_rdata[2:0]  = {w_irq_en_rd, 1'b0, r_tx_en};
                default: w_rdata       = 32'd0;
            endcase
        end
    end

    assign bus.r_data_mem = w_rdata;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] A_TXD  = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_DIV  = BASE + 32'h8;
    localparam logic [31:0] A_CTRL = BASE + 32'hC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx;
`ifdef MMIO_UART_TX_IRQ_EN
    logic irq;
`endif
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] rdv;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(16), .FIFO_DEPTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .tx(tx)
`ifdef MMIO_UART_TX_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.rw_addr_mem = a;
        bus.w_data_mem  = d;
        bus.r_ctrl_mem  = 1'b0;
        bus.w_ctrl_mem  = 1'b1;
        @(posedge clk);
        #1;
        bus.w_ctrl_mem  = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        @(negedge clk);
        bus.rw_addr_mem = a;
        bus.r_ctrl_mem  = 1'b1;
        #1;
        d = bus.r_data_mem;
        bus.r_ctrl_mem  = 1'b0;
        chk(tag, d, exp);
    endtask

    // Expected line level c cycles after the TXDATA store edge: pop at +1, start bit from +2
    function automatic logic exp_tx(input logic [7:0] b, input int d, input int c);
        int bi;
        if (c < 2) return 1'b1;
        if (c - 2 < d) return 1'b0;
        bi = (c - 2 - d) / d;
        if (bi < 8) return b[bi];
        return 1'b1;
    endfunction

    task automatic frame_chk(input string tag, input logic [7:0] b, input int d);
        bus.rw_addr_mem = A_STAT;
        bus.r_ctrl_mem  = 1'b1;
        for (int c = 1; c <= 10 * d + 2; c++) begin
            @(posedge clk);
            #1;
            chk({tag, "_tx"}, 32'(tx), 32'(exp_tx(b, d, c)));
            chk({tag, "_busy"}, 32'(bus.r_data_mem[0]), 32'(c <= 10 * d));
        end
        bus.r_ctrl_mem = 1'b0;
    endtask

    initial begin
        bus.rw_addr_mem = 32'd0;
        bus.w_data_mem  = 32'd0;
        bus.r_ctrl_mem  = 1'b0;
        bus.w_ctrl_mem  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_held", 32'(tx), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // 1: reset state
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        rdchk("rst_status", A_STAT, 32'h004);
        rdchk("rst_div", A_DIV, 32'd16);
        rdchk("rst_ctrl", A_CTRL, 32'd0);

        // 2: one frame at divisor 4
        wr(A_DIV, 32'd4);
        wr(A_CTRL, 32'd1);
        wr(A_TXD, 32'h55);
        frame_chk("f55", 8'h55, 4);

        // 3: overflow, clear, ordered drain with one idle cycle between frames
        wr(A_CTRL, 32'd0);
        for (int i = 0; i < 9; i++) wr(A_TXD, 32'h10 + 32'(i));
        rdchk("ovf_status", A_STAT, 32'h08A);
        wr(A_CTRL, 32'd2);
        rdchk("ovf_clr_status", A_STAT, 32'h082);
        wr(A_CTRL, 32'd1);
        for (int c = 1; c <= 2 + 41 * 8; c++) begin
            logic       e;
            logic [7:0] bv;
            int         k, r;
            @(posedge clk);
            #1;
            if (c < 2) e = 1'b1;
            else begin
                k = (c - 2) / 41;
                r = (c - 2) % 41;
                bv = 8'(8'h10 + k);
                if (k >= 8)      e = 1'b1;
                else if (r < 4)  e = 1'b0;
                else if (r < 36) e = bv[(r - 4) / 4];
                else             e = 1'b1;
            end
            chk("drain_tx", 32'(tx), 32'(e));
        end
        rdchk("drain_status", A_STAT, 32'h004);

        // 4: divisor 0 stored as 1, 10-cycle frame
        wr(A_DIV, 32'd0);
        rdchk("div0_read", A_DIV, 32'd1);
        wr(A_TXD, 32'hA3);
        frame_chk("fA3", 8'hA3, 1);

        // 5a: divisor write mid-frame leaves current frame at the latched length
        wr(A_TXD, 32'h3C);
        wr(A_DIV, 32'd8);
        bus.rw_addr_mem = A_STAT;
        bus.r_ctrl_mem  = 1'b1;
        for (int c = 2; c <= 12; c++) begin
            @(posedge clk);
            #1;
            chk("middiv_tx", 32'(tx), 32'(exp_tx(8'h3C, 1, c)));
            chk("middiv_busy", 32'(bus.r_data_mem[0]), 32'(c <= 10));
        end
        bus.r_ctrl_mem = 1'b0;
        rdchk("middiv_read", A_DIV, 32'd8);

        // 5b: reset mid-frame
        wr(A_TXD, 32'h00);
        repeat (19) @(posedge clk);
        @(negedge clk);
        chk("prerst_tx", 32'(tx), 32'(exp_tx(8'h00, 8, 19)));
        rst = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        bus.r_ctrl_mem  = 1'b1;
        bus.rw_addr_mem = A_STAT;
        #1;
        chk("midrst_status", bus.r_data_mem, 32'h004);
        bus.rw_addr_mem = A_DIV;
        #1;
        chk("midrst_div", bus.r_data_mem, 32'd16);
        bus.rw_addr_mem = A_CTRL;
        #1;
        chk("midrst_ctrl", bus.r_data_mem, 32'd0);
        bus.r_ctrl_mem = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_tx", 32'(tx), 32'd1);
        rdchk("postrst_status", A_STAT, 32'h004);

        // 6: decode misses and ignored address bits
        rdchk("miss_rd_hi", BASE + 32'h14, 32'd0);
        rdchk("miss_rd_zero", 32'h4, 32'd0);
        wr(BASE + 32'h18, 32'd5);
        wr(32'h8, 32'd5);
        wr(BASE + 32'h10, 32'hAA);
        wr(32'h0, 32'hAA);
        wr(BASE + 32'h1C, 32'd1);
        rdchk("miss_div", A_DIV, 32'd16);
        rdchk("miss_status", A_STAT, 32'h004);
        rdchk("miss_ctrl", A_CTRL, 32'd0);
        @(negedge clk);
        bus.rw_addr_mem = A_DIV;
        bus.r_ctrl_mem  = 1'b0;
        #1;
        chk("no_strobe_rd", bus.r_data_mem, 32'd0);
        rdchk("lsb_ignored_rd", BASE + 32'hA, 32'd16);
        wr(BASE + 32'hB, 32'd3);
        rdchk("lsb_ignored_wr", A_DIV, 32'd3);
        rdchk("txdata_reads0", A_TXD, 32'd0);
        wr(A_CTRL, 32'd6);
`ifdef MMIO_UART_TX_IRQ_EN
        rdchk("ctrl_rb", A_CTRL, 32'd4);
        wr(A_DIV, 32'd1);
        wr(A_CTRL, 32'd5);
        chk("irq_idle", 32'(irq), 32'd1);
        wr(A_TXD, 32'hC3);
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk);
            #1;
            chk("irq_frame", 32'(irq), 32'(c >= 12));
        end
`else
        rdchk("ctrl_rb", A_CTRL, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
